// File: rtl/pfs_sub4_pkg.sv
// pfs_pkg: shared definitions for the pipelined ripple-borrow subtractor.
//   WIDTH      default operand width, which is also the pipeline depth
//   operand_t  WIDTH-bit operand vector
//   stage_t    per-stage pipeline record
//   stage_clear() returns an all-zero stage record, used for reset
// Optional feature macro used by the top: PFS_SUB4_OVF_EN (no effect here).
package pfs_pkg;

  localparam int WIDTH = 4;

  typedef logic [WIDTH-1:0] operand_t;

  // One pipeline slot. a_rem/b_rem shift right by one bit per stage, so the
  // bit a stage works on is always at index 0.
  typedef struct packed {
    logic     valid;
    operand_t a_rem;
    operand_t b_rem;
    operand_t diff_acc;
    operand_t borrow_acc;
    logic     bi;
  } stage_t;

  function automatic stage_t stage_clear();
    stage_t s;
    s.valid      = 1'b0;
    s.a_rem      = {WIDTH{1'b0}};
    s.b_rem      = {WIDTH{1'b0}};
    s.diff_acc   = {WIDTH{1'b0}};
    s.borrow_acc = {WIDTH{1'b0}};
    s.bi         = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/pfs_sub4_full_sub_cell.sv
// full_sub_cell: combinational 1-bit full subtractor.
//   i_a   minuend bit
//   i_b   subtrahend bit
//   i_bi  borrow-in
//   o_d   difference bit  = a ^ b ^ bi
//   o_bo  borrow-out      = (~a & b) | (~(a ^ b) & bi)
module full_sub_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bi,
  output logic o_d,
  output logic o_bo
);

  logic w_axb;

  assign w_axb = i_a ^ i_b;
  assign o_d   = w_axb ^ i_bi;
  assign o_bo  = (~i_a & i_b) | (~w_axb & i_bi);

endmodule

// File: rtl/pfs_sub4.sv
// pfs_sub4: pipelined ripple-borrow subtractor, diff = a - b - bin, one bit
// resolved per pipeline stage, valid/ready flow control on both sides.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   in_valid   operand beat present
//   in_ready   stage 0 can accept a beat (combinational from valid bits and
//              out_ready only)
//   a, b, bin  minuend, subtrahend, borrow-in
//   out_valid  result beat present
//   out_ready  sink accepts the result
//   diff       a - b - bin modulo 2^WIDTH
//   borrow     per-bit borrow-out, borrow[WIDTH-1] is the final borrow
//   ovf        (only with PFS_SUB4_OVF_EN) signed two's-complement overflow,
//              aligned with diff
// Configuration macro: PFS_SUB4_OVF_EN adds the ovf port and its register.
// The stage record width comes from pfs_pkg::WIDTH, so WIDTH is expected to
// stay equal to the package value.
module pfs_sub4 #(
  parameter int WIDTH = pfs_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow
`ifdef PFS_SUB4_OVF_EN
  ,
  output logic             ovf
`endif
);

  import pfs_pkg::*;

  stage_t           r_stage [WIDTH];
  stage_t           w_src   [WIDTH];
  stage_t           w_nxt   [WIDTH];
  logic [WIDTH-1:0] w_valid;
  logic [WIDTH-1:0] w_ready;
  logic [WIDTH-1:0] w_cell_a;
  logic [WIDTH-1:0] w_cell_b;
  logic [WIDTH-1:0] w_cell_bi;
  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_bo;
  logic             w_unused_tail;

  // Gather stage valid bits into a vector for the ready computation.
  always_comb begin
    w_valid = {WIDTH{1'b0}};
    for (int k = 0; k < WIDTH; k++) begin
      w_valid[k] = r_stage[k].valid;
    end
  end

  // Stage k may load when it is empty, or when every stage from k to the
  // output is full and the sink takes the head: i.e. some stage at or
  // downstream of k is empty, or out_ready. Written as a flat reduction
  // rather than a ripple so that in_ready drops only when the whole pipe is
  // full and stalled, and upstream bubbles compress.
  always_comb begin
    w_ready = {WIDTH{1'b0}};
    for (int k = 0; k < WIDTH; k++) begin
      w_ready[k] = out_ready | ~(&(w_valid | ~({WIDTH{1'b1}} << k)));
    end
  end

  assign in_ready = w_ready[0];

  // Select each stage's source record and present its current bit to the cell.
  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      if (k == 0) begin
        w_src[k].valid      = in_valid;
        w_src[k].a_rem      = a;
        w_src[k].b_rem      = b;
        w_src[k].diff_acc   = {WIDTH{1'b0}};
        w_src[k].borrow_acc = {WIDTH{1'b0}};
        w_src[k].bi         = bin;
      end else begin
        w_src[k] = r_stage[k-1];
      end
      w_cell_a[k]  = w_src[k].a_rem[0];
      w_cell_b[k]  = w_src[k].b_rem[0];
      w_cell_bi[k] = w_src[k].bi;
    end
  end

  for (genvar k = 0; k < WIDTH; k++) begin : g_cell
    full_sub_cell u_cell (
      .i_a  (w_cell_a[k]),
      .i_b  (w_cell_b[k]),
      .i_bi (w_cell_bi[k]),
      .o_d  (w_d[k]),
      .o_bo (w_bo[k])
    );
  end

  // Build each stage's next record: consume one operand bit, deposit bit k.
  always_comb begin
    for (int k = 0; k < WIDTH; k++) begin
      w_nxt[k].valid         = w_src[k].valid;
      w_nxt[k].a_rem         = w_src[k].a_rem >> 1;
      w_nxt[k].b_rem         = w_src[k].b_rem >> 1;
      w_nxt[k].diff_acc      = w_src[k].diff_acc;
      w_nxt[k].diff_acc[k]   = w_d[k];
      w_nxt[k].borrow_acc    = w_src[k].borrow_acc;
      w_nxt[k].borrow_acc[k] = w_bo[k];
      w_nxt[k].bi            = w_bo[k];
    end
  end

  // Stage registers: a loading stage takes a valid source record, or becomes
  // a bubble while keeping its old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < WIDTH; k++) begin
        r_stage[k] <= stage_clear();
      end
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        if (w_ready[k]) begin
          if (w_src[k].valid) begin
            r_stage[k] <= w_nxt[k];
          end else begin
            r_stage[k].valid <= 1'b0;
          end
        end
      end
    end
  end

  assign out_valid = r_stage[WIDTH-1].valid;
  assign diff      = r_stage[WIDTH-1].diff_acc;
  assign borrow    = r_stage[WIDTH-1].borrow_acc;

  // The last stage's leftover operand bits and running borrow are not needed.
  assign w_unused_tail = ^{r_stage[WIDTH-1].a_rem, r_stage[WIDTH-1].b_rem,
                           r_stage[WIDTH-1].bi};

`ifdef PFS_SUB4_OVF_EN
  logic r_ovf;

  // Overflow is formed where the sign bits reach the last cell, so it loads
  // in lockstep with diff.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf <= 1'b0;
    end else if (w_ready[WIDTH-1] && w_src[WIDTH-1].valid) begin
      r_ovf <= (w_cell_a[WIDTH-1] ^ w_cell_b[WIDTH-1]) &
               (w_cell_a[WIDTH-1] ^ w_d[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pfs_sub4.sv
// tb_pfs_sub4: scoreboard bench for pfs_sub4. Accepted beats push the
// reference result into a queue; a monitor pops and compares whenever a
// result is consumed. The reference is plain integer arithmetic.
module tb_pfs_sub4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic [W-1:0] borrow;
`ifdef PFS_SUB4_OVF_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] diff;
    logic [W-1:0] borrow;
    logic         ovf;
  } exp_t;

  exp_t         exp_q[$];
  int           occ = 0;
  int           checks = 0;
  int           errors = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_diff = '0;
  logic [W-1:0] prev_borrow = '0;

  pfs_sub4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef PFS_SUB4_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: diff by modular arithmetic, borrow[k] = whether the low k+1
  // bits of a are smaller than those of b plus bin, ovf by signed range.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mbin);
    exp_t e;
    int ai, bi, ci, t, m, sa, sb, r;
    ai = int'(ma);
    bi = int'(mb);
    ci = int'(mbin);
    t = ai - bi - ci;
    e.diff = t[W-1:0];
    for (int k = 0; k < W; k++) begin
      m = 1 << (k + 1);
      e.borrow[k] = ((ai % m) < ((bi % m) + ci));
    end
    sa = ma[W-1] ? ai - (1 << W) : ai;
    sb = mb[W-1] ? bi - (1 << W) : bi;
    r = sa - sb - ci;
    e.ovf = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: samples on the falling edge, for the handshakes at the next rise.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      occ = 0;
      prev_stall = 1'b0;
    end else begin
      check("IN_READY", int'(in_ready), int'(!(occ == W && !out_ready)));
      if (prev_stall && out_valid) begin
        check("STALL_DIFF", int'(diff), int'(prev_diff));
        check("STALL_BORROW", int'(borrow), int'(prev_borrow));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("STALE_OUT", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("DIFF", int'(diff), int'(e.diff));
          check("BORROW", int'(borrow), int'(e.borrow));
`ifdef PFS_SUB4_OVF_EN
          check("OVF", int'(ovf), int'(e.ovf));
`endif
          occ--;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, bin));
        occ++;
      end
      prev_stall  = out_valid && !out_ready;
      prev_diff   = diff;
      prev_borrow = borrow;
    end
  end

  // One beat into an empty pipe with out_ready=1; checks latency and the
  // hand-derived result.
  task automatic directed(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input logic [W-1:0] ed,
                          input logic [W-1:0] eb);
    int n;
    a = ta;
    b = tb;
    bin = tbin;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    check("LATENCY", n, W - 1);
    check("D_DIFF", int'(diff), int'(ed));
    check("D_BORROW", int'(borrow), int'(eb));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int cycles);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 check("DRAIN", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL WATCHDOG actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("RST_OUT_VALID", int'(out_valid), 0);
    check("RST_DIFF", int'(diff), 0);
    check("RST_BORROW", int'(borrow), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 check("REL_IN_READY", int'(in_ready), 1);

    directed(4'd5, 4'd3, 1'b0, 4'b0010, 4'b0010);
    directed(4'd3, 4'd5, 1'b0, 4'b1110, 4'b1100);
    directed(4'd0, 4'd0, 1'b1, 4'b1111, 4'b1111);
    directed(4'd0, 4'd1, 1'b0, 4'b1111, 4'b1111);

    // Back-to-back random stream.
    for (int i = 0; i < 16; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    drain(8);

    // Back-pressure: more offers than slots with the sink stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    check("FULL_IN_READY", int'(in_ready), 0);
    check("FULL_OCC", occ, W);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 drain(8);

    // Random valid/ready mix to exercise bubbles and partial stalls.
    for (int i = 0; i < 300; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain(12);

    // Reset with three beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 check("PRE_RST_VALID", int'(out_valid), 1);
    #1 rst = 1'b0;
    #1;
    check("ASYNC_RST_VALID", int'(out_valid), 0);
    check("ASYNC_RST_DIFF", int'(diff), 0);
    check("ASYNC_RST_BORROW", int'(borrow), 0);
    @(posedge clk);
    @(negedge clk) begin
      rst = 1'b1;
      out_ready = 1'b1;
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check("NO_STALE", int'(out_valid), 0);
    end
    directed(4'd9, 4'd9, 1'b0, 4'b0000, 4'b0000);
    drain(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
